// File: rtl/reservation_station_param.sv
// Parametrised Tomasulo reservation station: multi-CDB operand snooping, flush, registered valid/ready issue port.
// Optional macro RS_OLDEST_FIRST_EN: issue the oldest ready slot instead of the lowest-index ready slot.
module reservation_station_param #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 3,
    parameter int DATA_W      = 32,
    parameter int NUM_CDB     = 1,
    parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [2:0]                alloc_op,
    input  logic [2:0]                alloc_funct3,
    input  logic                      alloc_funct7,
    input  logic [TAG_W-1:0]          alloc_src1_tag,
    input  logic [TAG_W-1:0]          alloc_src2_tag,
    input  logic [DATA_W-1:0]         alloc_src1_data,
    input  logic [DATA_W-1:0]         alloc_src2_data,
    input  logic                      alloc_src1_valid,
    input  logic                      alloc_src2_valid,
    input  logic [TAG_W-1:0]          alloc_rd,
    input  logic [DATA_W-1:0]         alloc_imm,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [2:0]                issue_op,
    output logic [2:0]                issue_funct3,
    output logic                      issue_funct7,
    output logic [DATA_W-1:0]         issue_src1_data,
    output logic [DATA_W-1:0]         issue_src2_data,
    output logic [DATA_W-1:0]         issue_imm,
    output logic [TAG_W-1:0]          issue_rd,
    output logic [CNT_W-1:0]          occupancy
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef struct packed {
        logic              valid;
        logic [2:0]        op;
        logic [2:0]        funct3;
        logic              funct7;
        logic [TAG_W-1:0]  rd;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic              rdy1;
        logic              rdy2;
    } slot_t;

    slot_t                  slots [NUM_ENTRIES];
    slot_t                  alloc_entry;
    logic [NUM_ENTRIES-1:0] hit1, hit2, slot_ready;
    logic [DATA_W-1:0]      cap1 [NUM_ENTRIES];
    logic [DATA_W-1:0]      cap2 [NUM_ENTRIES];
    logic [DATA_W:0]        alloc_snoop1, alloc_snoop2;
    logic [IDX_W-1:0]       alloc_idx, sel_idx;
    logic                   alloc_fire, sel_found, issue_load;

`ifdef RS_OLDEST_FIRST_EN
    localparam int AGE_W = 16;
    logic [AGE_W-1:0] age [NUM_ENTRIES];
    logic [AGE_W-1:0] sel_age;
`endif

    // Returns {hit, data}; the lowest-index matching bus wins.
    function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] res;
        res = '0;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (cdb_valid[b] && cdb_tag[b*TAG_W +: TAG_W] == tag)
                res = {1'b1, cdb_data[b*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    assign alloc_ready = (occupancy != CNT_W'(NUM_ENTRIES));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign issue_load  = (!issue_valid || issue_ready) && sel_found;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (!slots[i].valid) alloc_idx = IDX_W'(i);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            {hit1[i], cap1[i]} = snoop(slots[i].tag1);
            {hit2[i], cap2[i]} = snoop(slots[i].tag2);
            slot_ready[i]      = slots[i].valid && slots[i].rdy1 && slots[i].rdy2;
        end
        alloc_snoop1       = snoop(alloc_src1_tag);
        alloc_snoop2       = snoop(alloc_src2_tag);
        alloc_entry        = '0;
        alloc_entry.valid  = 1'b1;
        alloc_entry.op     = alloc_op;
        alloc_entry.funct3 = alloc_funct3;
        alloc_entry.funct7 = alloc_funct7;
        alloc_entry.rd     = alloc_rd;
        alloc_entry.imm    = alloc_imm;
        alloc_entry.tag1   = alloc_src1_tag;
        alloc_entry.tag2   = alloc_src2_tag;
        alloc_entry.rdy1   = alloc_src1_valid || alloc_snoop1[DATA_W];
        alloc_entry.rdy2   = alloc_src2_valid || alloc_snoop2[DATA_W];
        alloc_entry.data1  = alloc_src1_valid ? alloc_src1_data : alloc_snoop1[DATA_W-1:0];
        alloc_entry.data2  = alloc_src2_valid ? alloc_src2_data : alloc_snoop2[DATA_W-1:0];
    end

    // Selection looks only at registered ready flags, so a CDB hit issues one edge later.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
        sel_age   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (slot_ready[i] && (!sel_found || age[i] > sel_age)) begin
                sel_idx   = IDX_W'(i);
                sel_age   = age[i];
                sel_found = 1'b1;
            end
        end
`else
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (slot_ready[i]) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
`endif
    end

    // NOTE: non-blocking assignments keep every slot update based on pre-edge state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // NOTE: only the valid bits are cleared; payload of an invalid slot is never observed.
            for (int i = 0; i < NUM_ENTRIES; i++)
                slots[i].valid <= 1'b0;
            issue_valid     <= 1'b0;
            issue_op        <= '0;
            issue_funct3    <= '0;
            issue_funct7    <= 1'b0;
            issue_src1_data <= '0;
            issue_src2_data <= '0;
            issue_imm       <= '0;
            issue_rd        <= '0;
            occupancy       <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (slots[i].valid && !slots[i].rdy1 && hit1[i]) begin
                    slots[i].rdy1  <= 1'b1;
                    slots[i].data1 <= cap1[i];
                end
                if (slots[i].valid && !slots[i].rdy2 && hit2[i]) begin
                    slots[i].rdy2  <= 1'b1;
                    slots[i].data2 <= cap2[i];
                end
                if (issue_load && sel_idx == IDX_W'(i))
                    slots[i].valid <= 1'b0;
                if (alloc_fire && alloc_idx == IDX_W'(i))
                    slots[i] <= alloc_entry;
            end
            if (issue_load) begin
                issue_valid     <= 1'b1;
                issue_op        <= slots[sel_idx].op;
                issue_funct3    <= slots[sel_idx].funct3;
                issue_funct7    <= slots[sel_idx].funct7;
                issue_src1_data <= slots[sel_idx].data1;
                issue_src2_data <= slots[sel_idx].data2;
                issue_imm       <= slots[sel_idx].imm;
                issue_rd        <= slots[sel_idx].rd;
            end else if (issue_ready) begin
                issue_valid <= 1'b0;
            end
            occupancy <= occupancy + CNT_W'(alloc_fire) - CNT_W'(issue_load);
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // Ages saturate; they only need to order live slots relative to each other.
    always_ff @(posedge clk) begin
        if (!rst && !flush && alloc_fire) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (alloc_idx == IDX_W'(i))
                    age[i] <= '0;
                else if (age[i] != '1)
                    age[i] <= age[i] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reservation_station_param.sv
// Self-checking bench for reservation_station_param (4 slots, 2 CDBs): directed scenarios plus
// randomized traffic compared every cycle against a slot-pool reference model.
module tb_reservation_station_param;
    localparam int N  = 4;
    localparam int TW = 3;
    localparam int DW = 32;
    localparam int NC = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, flush, alloc_valid, alloc_ready, alloc_funct7;
    logic [2:0]     alloc_op, alloc_funct3;
    logic [TW-1:0]  alloc_src1_tag, alloc_src2_tag, alloc_rd;
    logic [DW-1:0]  alloc_src1_data, alloc_src2_data, alloc_imm;
    logic           alloc_src1_valid, alloc_src2_valid;
    logic [NC-1:0]  cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*DW-1:0] cdb_data;
    logic           issue_valid, issue_ready, issue_funct7;
    logic [2:0]     issue_op, issue_funct3;
    logic [DW-1:0]  issue_src1_data, issue_src2_data, issue_imm;
    logic [TW-1:0]  issue_rd;
    logic [CW-1:0]  occupancy;

    int tests = 0;
    int fails = 0;

    reservation_station_param #(
        .NUM_ENTRIES(N), .TAG_W(TW), .DATA_W(DW), .NUM_CDB(NC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_op(alloc_op), .alloc_funct3(alloc_funct3), .alloc_funct7(alloc_funct7),
        .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
        .alloc_src1_data(alloc_src1_data), .alloc_src2_data(alloc_src2_data),
        .alloc_src1_valid(alloc_src1_valid), .alloc_src2_valid(alloc_src2_valid),
        .alloc_rd(alloc_rd), .alloc_imm(alloc_imm),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_src1_data(issue_src1_data), .issue_src2_data(issue_src2_data),
        .issue_imm(issue_imm), .issue_rd(issue_rd), .occupancy(occupancy)
    );

    // Reference model: an unordered pool of ops plus the op held for the functional unit.
    typedef struct {
        bit            v;
        bit [2:0]      op, f3;
        bit            f7;
        bit [TW-1:0]   rd, t1, t2;
        bit [DW-1:0]   imm, d1, d2;
        bit            r1, r2;
        int            age;
    } m_slot_t;

    m_slot_t       ms [N];
    bit            m_iv;
    bit [105:0]    m_ifields;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (ms[i].v) c++;
        return c;
    endfunction

    function automatic bit bus_hit(input bit [TW-1:0] t, output bit [DW-1:0] d);
        for (int b = 0; b < NC; b++) begin
            if (cdb_valid[b] && cdb_tag[b*TW +: TW] == t) begin
                d = cdb_data[b*DW +: DW];
                return 1'b1;
            end
        end
        d = '0;
        return 1'b0;
    endfunction

    task automatic model_edge();
        int      sel, fr;
        bit      fire;
        bit [DW-1:0] d;
        m_slot_t e;
        if (rst || flush) begin
            for (int i = 0; i < N; i++) ms[i].v = 1'b0;
            m_iv = 1'b0;
            m_ifields = '0;
            return;
        end
        sel = -1;
        for (int i = 0; i < N; i++) begin
            if (ms[i].v && ms[i].r1 && ms[i].r2) begin
`ifdef RS_OLDEST_FIRST_EN
                if (sel < 0 || ms[i].age > ms[sel].age) sel = i;
`else
                if (sel < 0) sel = i;
`endif
            end
        end
        fr = -1;
        for (int i = 0; i < N; i++) if (!ms[i].v && fr < 0) fr = i;
        fire = alloc_valid && (m_count() != N);
        for (int i = 0; i < N; i++) begin
            if (ms[i].v && !ms[i].r1 && bus_hit(ms[i].t1, d)) begin ms[i].r1 = 1'b1; ms[i].d1 = d; end
            if (ms[i].v && !ms[i].r2 && bus_hit(ms[i].t2, d)) begin ms[i].r2 = 1'b1; ms[i].d2 = d; end
        end
        if (sel >= 0 && (!m_iv || issue_ready)) begin
            m_iv = 1'b1;
            m_ifields = {ms[sel].op, ms[sel].f3, ms[sel].f7, ms[sel].rd, ms[sel].d1, ms[sel].d2, ms[sel].imm};
            ms[sel].v = 1'b0;
        end else if (issue_ready) begin
            m_iv = 1'b0;
        end
        if (fire) begin
            for (int i = 0; i < N; i++) if (ms[i].v) ms[i].age++;
            e.v = 1'b1; e.op = alloc_op; e.f3 = alloc_funct3; e.f7 = alloc_funct7;
            e.rd = alloc_rd; e.imm = alloc_imm; e.t1 = alloc_src1_tag; e.t2 = alloc_src2_tag;
            e.age = 0;
            if (alloc_src1_valid) begin e.r1 = 1'b1; e.d1 = alloc_src1_data; end
            else e.r1 = bus_hit(alloc_src1_tag, e.d1);
            if (alloc_src2_valid) begin e.r2 = 1'b1; e.d2 = alloc_src2_data; end
            else e.r2 = bus_hit(alloc_src2_tag, e.d2);
            ms[fr] = e;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
        alloc_op = '0; alloc_funct3 = '0; alloc_funct7 = 1'b0;
        alloc_src1_tag = '0; alloc_src2_tag = '0; alloc_src1_data = '0; alloc_src2_data = '0;
        alloc_src1_valid = 1'b0; alloc_src2_valid = 1'b0; alloc_rd = '0; alloc_imm = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic drive_alloc(input bit [TW-1:0] rd, input bit [TW-1:0] t1, input bit v1,
                               input bit [DW-1:0] d1, input bit [TW-1:0] t2, input bit v2,
                               input bit [DW-1:0] d2);
        alloc_valid = 1'b1; alloc_op = 3'd0; alloc_funct3 = 3'd0; alloc_funct7 = 1'b0;
        alloc_rd = rd; alloc_imm = 32'h1000 + DW'(rd);
        alloc_src1_tag = t1; alloc_src1_valid = v1; alloc_src1_data = d1;
        alloc_src2_tag = t2; alloc_src2_valid = v2; alloc_src2_data = d2;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; flush = 1'b1; issue_ready = 1'b0;
        drive_alloc(3'd1, 3'd0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd2);
        cdb_valid = 2'b11; cdb_tag = 6'o21; cdb_data = {32'd5, 32'd6};
        step();
        step();
        tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready); end
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL reset_issue_valid got %b exp 0", issue_valid); end
        tests++;
        if ({issue_op, issue_funct3, issue_funct7, issue_rd, issue_src1_data, issue_src2_data, issue_imm} !== 106'd0) begin
            fails++; $display("FAIL reset_issue_fields got %h exp 0",
                {issue_op, issue_funct3, issue_funct7, issue_rd, issue_src1_data, issue_src2_data, issue_imm});
        end
        idle();
    endtask

    task automatic test_basic();
        do_reset();
        issue_ready = 1'b1;
        drive_alloc(3'd3, 3'd0, 1'b1, 32'd5, 3'd0, 1'b1, 32'd7);
        step();
        idle();
        tests++; if (occupancy !== 3'd1) begin fails++; $display("FAIL basic_occ_e0 got %0d exp 1", occupancy); end
        tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_e0 got %b exp 0", issue_valid); end
        step();
        tests++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_e1 got %b exp 1", issue_valid); end
        tests++; if (issue_src1_data !== 32'd5 || issue_src2_data !== 32'd7 || issue_rd !== 3'd3) begin
            fails++; $display("FAIL basic_fields got %0d/%0d/%0d exp 5/7/3", issue_src1_data, issue_src2_data, issue_rd); end
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL basic_occ_e1 got %0d exp 0", occupancy); end
    endtask

    task automatic test_cdb_wakeup();
        do_reset();
        issue_ready = 1'b1;
        drive_alloc(3'd5, 3'd2, 1'b0, 32'd0, 3'd0, 1'b1, 32'd1);
        step();
        idle();
        cdb_valid = 2'b01; cdb_tag = {3'd0, 3'd2}; cdb_data = {32'd0, 32'hDEADBEEF};
        step();
        idle();
        tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL wake_no_bypass got %b exp 0", issue_valid); end
        step();
        tests++; if (issue_valid !== 1'b1 || issue_src1_data !== 32'hDEADBEEF) begin
            fails++; $display("FAIL wake_issue got v=%b d=%h exp v=1 d=deadbeef", issue_valid, issue_src1_data); end
    endtask

    task automatic test_multi_cdb();
        do_reset();
        issue_ready = 1'b1;
        drive_alloc(3'd2, 3'd1, 1'b0, 32'd0, 3'd4, 1'b0, 32'd0);
        step();
        idle();
        cdb_valid = 2'b11; cdb_tag = {3'd1, 3'd4}; cdb_data = {32'd11, 32'd9};
        step();
        idle();
        step();
        tests++; if (issue_valid !== 1'b1 || issue_src1_data !== 32'd11 || issue_src2_data !== 32'd9) begin
            fails++; $display("FAIL multi_cdb got v=%b %0d/%0d exp v=1 11/9", issue_valid, issue_src1_data, issue_src2_data); end
    endtask

    task automatic test_alloc_snoop();
        do_reset();
        issue_ready = 1'b1;
        drive_alloc(3'd6, 3'd6, 1'b0, 32'd0, 3'd0, 1'b1, 32'd3);
        cdb_valid = 2'b01; cdb_tag = {3'd0, 3'd6}; cdb_data = {32'd0, 32'h55};
        step();
        idle();
        step();
        tests++; if (issue_valid !== 1'b1 || issue_src1_data !== 32'h55 || issue_src2_data !== 32'd3) begin
            fails++; $display("FAIL alloc_snoop got v=%b %h/%h exp v=1 55/3", issue_valid, issue_src1_data, issue_src2_data); end
    endtask

    task automatic test_backpressure();
        int exp_seq [4];
`ifdef RS_OLDEST_FIRST_EN
        exp_seq = '{1, 2, 3, 4};
`else
        exp_seq = '{2, 1, 3, 4};
`endif
        do_reset();
        issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_alloc(TW'(k), 3'd0, 1'b1, DW'(k * 10), 3'd0, 1'b1, DW'(k + 100));
            step();
        end
        tests++; if (occupancy !== 3'd4 || alloc_ready !== 1'b0) begin
            fails++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=4 rdy=0", occupancy, alloc_ready); end
        drive_alloc(3'd7, 3'd0, 1'b1, 32'd77, 3'd0, 1'b1, 32'd78);
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (issue_valid !== 1'b1 || issue_rd !== 3'd0 || issue_src2_data !== 32'd100 || occupancy !== 3'd4) begin
                fails++; $display("FAIL bp_hold got v=%b rd=%0d s2=%0d occ=%0d exp v=1 rd=0 s2=100 occ=4",
                    issue_valid, issue_rd, issue_src2_data, occupancy); end
        end
        idle();
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            tests++; if (issue_valid !== 1'b1 || issue_rd !== TW'(exp_seq[k])) begin
                fails++; $display("FAIL bp_drain%0d got v=%b rd=%0d exp v=1 rd=%0d", k, issue_valid, issue_rd, exp_seq[k]); end
            tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL bp_alloc_ready%0d got %b exp 1", k, alloc_ready); end
        end
        step();
        tests++; if (issue_valid !== 1'b0 || occupancy !== 3'd0) begin
            fails++; $display("FAIL bp_empty got v=%b occ=%0d exp v=0 occ=0", issue_valid, occupancy); end
    endtask

    task automatic test_flush();
        do_reset();
        issue_ready = 1'b1;
        drive_alloc(3'd1, 3'd5, 1'b0, 32'd0, 3'd0, 1'b1, 32'd1);
        step();
        drive_alloc(3'd2, 3'd6, 1'b0, 32'd0, 3'd0, 1'b1, 32'd2);
        step();
        tests++; if (occupancy !== 3'd2) begin fails++; $display("FAIL flush_pre_occ got %0d exp 2", occupancy); end
        flush = 1'b1;
        cdb_valid = 2'b01; cdb_tag = {3'd0, 3'd5}; cdb_data = {32'd0, 32'd9};
        step();
        idle();
        tests++; if (occupancy !== 3'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin
            fails++; $display("FAIL flush_state got occ=%0d v=%b rdy=%b exp 0/0/1", occupancy, issue_valid, alloc_ready); end
        cdb_valid = 2'b11; cdb_tag = {3'd6, 3'd5}; cdb_data = {32'd1, 32'd2};
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            step();
            tests++; if (issue_valid !== 1'b0 || occupancy !== 3'd0) begin
                fails++; $display("FAIL flush_stale%0d got v=%b occ=%0d exp v=0 occ=0", k, issue_valid, occupancy); end
        end
    endtask

    task automatic test_oldest();
        bit [TW-1:0] exp_rd;
`ifdef RS_OLDEST_FIRST_EN
        exp_rd = 3'd3;
`else
        exp_rd = 3'd4;
`endif
        do_reset();
        issue_ready = 1'b0;
        drive_alloc(3'd1, 3'd1, 1'b0, 32'd0, 3'd0, 1'b1, 32'd0);
        step();
        drive_alloc(3'd2, 3'd2, 1'b0, 32'd0, 3'd0, 1'b1, 32'd0);
        step();
        drive_alloc(3'd3, 3'd3, 1'b0, 32'd0, 3'd0, 1'b1, 32'd0);
        step();
        idle();
        cdb_valid = 2'b01; cdb_tag = {3'd0, 3'd1}; cdb_data = {32'd0, 32'd10};
        step();
        idle();
        step();
        drive_alloc(3'd4, 3'd4, 1'b0, 32'd0, 3'd0, 1'b1, 32'd0);
        step();
        idle();
        cdb_valid = 2'b11; cdb_tag = {3'd4, 3'd3}; cdb_data = {32'd40, 32'd30};
        step();
        idle();
        step();
        tests++; if (issue_valid !== 1'b1 || issue_rd !== 3'd1) begin
            fails++; $display("FAIL age_held got v=%b rd=%0d exp v=1 rd=1", issue_valid, issue_rd); end
        issue_ready = 1'b1;
        step();
        tests++; if (issue_valid !== 1'b1 || issue_rd !== exp_rd) begin
            fails++; $display("FAIL age_select got v=%b rd=%0d exp v=1 rd=%0d", issue_valid, issue_rd, exp_rd); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            flush            = ($urandom_range(0, 99) < 2);
            issue_ready      = ($urandom_range(0, 99) < 65);
            alloc_valid      = ($urandom_range(0, 99) < 60);
            alloc_op         = 3'($urandom_range(0, 7));
            alloc_funct3     = 3'($urandom_range(0, 7));
            alloc_funct7     = 1'($urandom_range(0, 1));
            alloc_rd         = TW'($urandom_range(0, 7));
            alloc_imm        = $urandom();
            alloc_src1_tag   = TW'($urandom_range(0, 7));
            alloc_src2_tag   = TW'($urandom_range(0, 7));
            alloc_src1_data  = $urandom();
            alloc_src2_data  = $urandom();
            alloc_src1_valid = ($urandom_range(0, 99) < 50);
            alloc_src2_valid = ($urandom_range(0, 99) < 50);
            cdb_valid        = NC'($urandom_range(0, 3));
            cdb_tag          = {TW'($urandom_range(0, 7)), TW'($urandom_range(0, 7))};
            if (cdb_tag[TW +: TW] == cdb_tag[0 +: TW]) cdb_tag[TW +: TW] = cdb_tag[0 +: TW] ^ 3'd1;
            cdb_data         = {$urandom(), $urandom()};
            step();
            tests++; if (alloc_ready !== (m_count() != N)) begin
                fails++; $display("FAIL rand_alloc_ready cyc %0d got %b exp %b", cyc, alloc_ready, (m_count() != N)); end
            tests++; if (occupancy !== CW'(m_count())) begin
                fails++; $display("FAIL rand_occupancy cyc %0d got %0d exp %0d", cyc, occupancy, m_count()); end
            tests++; if (issue_valid !== m_iv) begin
                fails++; $display("FAIL rand_issue_valid cyc %0d got %b exp %b", cyc, issue_valid, m_iv); end
            if (m_iv) begin
                tests++;
                if ({issue_op, issue_funct3, issue_funct7, issue_rd, issue_src1_data, issue_src2_data, issue_imm} !== m_ifields) begin
                    fails++; $display("FAIL rand_issue_fields cyc %0d got %h exp %h", cyc,
                        {issue_op, issue_funct3, issue_funct7, issue_rd, issue_src1_data, issue_src2_data, issue_imm}, m_ifields);
                end
            end
        end
    endtask

    initial begin
        idle();
        issue_ready = 1'b0;
        test_reset();
        test_basic();
        test_cdb_wakeup();
        test_multi_cdb();
        test_alloc_snoop();
        test_backpressure();
        test_flush();
        test_oldest();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reservation_station_param.md
Name: reservation_station_param

Overview:
Parametrised Tomasulo reservation station: a pool of NUM_ENTRIES slots holding decoded ALU ops with tagged source operands. Snoops NUM_CDB common data buses to capture operand values, selects a ready entry and delivers it through a registered valid/ready issue port to the functional unit. Sits between the dispatch/rename stage and an ALU. Adds depth, tag/data width, multi-CDB snooping and flush, which a single-bus fixed 3-bit-tag station lacks.

Parameters:
NUM_ENTRIES, 4, slot count (>=2)
TAG_W, 3, ROB/rename tag width
DATA_W, 32, operand/imm width
NUM_CDB, 1, number of broadcast buses snooped (>=1)
CNT_W, $clog2(NUM_ENTRIES+1), occupancy width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries and issue register
alloc_valid  in  1  dispatch presents an op
alloc_ready  out  1  slot available
alloc_op  in  3  op_t encoding
alloc_funct3  in  3  funct3
alloc_funct7  in  1  funct7 bit
alloc_src1_tag / alloc_src2_tag  in  TAG_W  producer tags
alloc_src1_data / alloc_src2_data  in  DATA_W  values when valid
alloc_src1_valid / alloc_src2_valid  in  1  value already available
alloc_rd  in  TAG_W  destination tag
alloc_imm  in  DATA_W  immediate
cdb_valid  in  NUM_CDB  per-bus broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  bus i at [i*TAG_W +: TAG_W]
cdb_data  in  NUM_CDB*DATA_W  bus i at [i*DATA_W +: DATA_W]
issue_valid  out  1  issue register holds an op
issue_ready  in  1  FU accepts
issue_op, issue_funct3, issue_funct7  out  3/3/1  op fields
issue_src1_data, issue_src2_data, issue_imm  out  DATA_W  operands
issue_rd  out  TAG_W  destination tag
occupancy  out  CNT_W  occupied slots (excl. issue register)

Behaviour:
- Reset (sync, rst high at edge): all slots invalid, issue register cleared, every output 0 except alloc_ready=1. rst dominates flush and all other inputs.
- Flush: at edge with flush=1, all slots and issue register invalidated, outputs as reset; alloc and CDB ignored that cycle.
- alloc_ready = (occupancy != NUM_ENTRIES); combinational from registered state; does not anticipate same-cycle issue frees.
- Allocation when alloc_valid && alloc_ready: written into lowest-index free slot at the edge.
- Wakeup: every cycle, for each valid slot operand with valid=0, if any cdb_valid[i] && cdb_tag[i]==stored tag, capture cdb_data[i], set valid. Same rule applies to alloc operands in the allocating cycle (alloc with src valid=0 and matching CDB stores the CDB value, valid=1). Multiple buses matching one tag in one cycle: illegal; lowest bus index wins.
- Ready slot: both stored valid flags 1. Selection uses registered flags only (no CDB-to-issue bypass).
- Issue register loads when (!issue_valid || issue_ready) and a ready slot exists; chosen slot freed at the same edge. If issue_valid && issue_ready and no ready slot, issue_valid drops to 0.
- Output fields stable while issue_valid && !issue_ready.
- Latency: alloc with both operands valid at edge E0 -> issue_valid high after E1. CDB wakeup at edge E0 -> issue_valid after E1 (if issue register free).
- Simultaneous alloc + issue in one cycle: both occur; occupancy net unchanged.
- occupancy: +1 on alloc, -1 on issue load, registered.

Optional Feature:
RS_OLDEST_FIRST_EN: when defined, each slot holds an age counter (reset on alloc, incremented on every other alloc); selection picks the ready slot with greatest age, ties to lowest index. When undefined, selection picks the lowest-index ready slot.

Test Plan:
- Reset then alloc ADD src1=5 valid, src2=7 valid, rd=3 -> issue_valid after 2 edges, src1=5, src2=7, rd=3, occupancy back to 0.
- Alloc src1 tag=2 invalid; next cycle cdb_valid=1 tag=2 data=0xDEADBEEF -> issue_src1_data=0xDEADBEEF one cycle later.
- NUM_CDB=2: alloc waiting on tags 1 and 4; bus0 tag=4 data=9 and bus1 tag=1 data=11 same cycle -> both captured, issue src1=11, src2=9.
- Alloc src1 tag=6 invalid in same cycle cdb tag=6 data=0x55 -> slot captures 0x55, issues without further broadcast.
- Fill 4 slots, issue_ready=0 -> alloc_ready=0, issue fields held; raise issue_ready -> one issue per cycle, alloc_ready returns to 1.
- Slots pending, assert flush -> next cycle occupancy=0, issue_valid=0; later CDB for old tags produces no issue; with RS_OLDEST_FIRST_EN, slot 2 older than slot 0, both ready -> slot 2 issues first.
